systolic_drain: RTL and testbench

Result reader for the systolic array: on a `start` pulse it snapshots the full C accumulator matrix, clears the array accumulators via their per-PE soft resets, and streams the captured results out row-major over a valid/ready interface. It sits between the array's `c_array_output` and the downstream result sink/writeback logic. Capturing first lets the array begin the next tile while results drain.

---
 rtl/systolic_drain.sv | 117 +++++++++++
 tb/tb_systolic_drain.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_drain: snapshots the C accumulators, clears the array, and        |
// | streams results row-major over valid/ready.   Rev 1.0                      |
// +----------------------------------------------------------------------------+
module systolic_drain #(
  parameter int ARRAY_WIDTH  = 2,
  parameter int ARRAY_HEIGHT = 2,
  parameter int DATA_WIDTH   = 8,
  localparam int RW = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1,
  localparam int CW = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2*DATA_WIDTH-1:0]   c_array_input [ARRAY_HEIGHT][ARRAY_WIDTH],
  output logic                      array_reset_n [ARRAY_HEIGHT][ARRAY_WIDTH],
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   out_data,
  output logic [RW-1:0]             out_row,
  output logic [CW-1:0]             out_col,
  output logic                      out_last
);

  localparam logic [RW-1:0] C_LAST_ROW = RW'(ARRAY_HEIGHT - 1);
  localparam logic [CW-1:0] C_LAST_COL = CW'(ARRAY_WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [RW-1:0]           r_row;
  logic [CW-1:0]           r_col;
  logic                    r_clr_n;
  logic [2*DATA_WIDTH-1:0] r_snap [ARRAY_HEIGHT][ARRAY_WIDTH];

  logic w_accept;
  logic w_xfer;
  logic w_at_last;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_xfer    = (r_state == STREAM) && out_ready;
  assign w_at_last = (r_row == C_LAST_ROW) && (r_col == C_LAST_COL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = STREAM;
      STREAM:  if (out_ready && w_at_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Counters walk row-major; a degenerate dimension simply never leaves 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row   <= '0;
      r_col   <= '0;
      r_clr_n <= 1'b1;
    end else begin
      r_clr_n <= !w_accept;
      if (w_accept) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_xfer) begin
        if (w_at_last) begin
          r_row <= '0;
          r_col <= '0;
        end else if (r_col == C_LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  // Snapshot needs no reset; it is only read while streaming.
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      for (int r = 0; r < ARRAY_HEIGHT; r++) begin
        for (int c = 0; c < ARRAY_WIDTH; c++) begin
          r_snap[r][c] <= c_array_input[r][c];
        end
      end
    end
  end

  assign busy      = (r_state == STREAM);
  assign out_valid = busy;
  assign out_row   = r_row;
  assign out_col   = r_col;
  assign out_data  = busy ? r_snap[r_row][r_col] : '0;
  assign out_last  = busy && w_at_last;

  for (genvar gr = 0; gr < ARRAY_HEIGHT; gr++) begin : g_rst_row
    for (genvar gc = 0; gc < ARRAY_WIDTH; gc++) begin : g_rst_col
      assign array_reset_n[gr][gc] = r_clr_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_systolic_drain: 2x2 and 3x1 drains against a queue-based beat model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_systolic_drain;

  typedef struct {
    logic [15:0] d;
    int          r;
    int          c;
    bit          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 2x2 instance
  logic        start_a, ready_a;
  logic [15:0] c_a [2][2];
  logic        arn_a [2][2];
  logic        busy_a, valid_a, last_a;
  logic [15:0] data_a;
  logic [0:0]  row_a, col_a;

  // 3x1 instance
  logic        start_b, ready_b;
  logic [15:0] c_b [3][1];
  logic        arn_b [3][1];
  logic        busy_b, valid_b, last_b;
  logic [15:0] data_b;
  logic [1:0]  row_b;
  logic [0:0]  col_b;

  systolic_drain #(.ARRAY_WIDTH(2), .ARRAY_HEIGHT(2), .DATA_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .c_array_input(c_a),
    .array_reset_n(arn_a), .busy(busy_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_data(data_a), .out_row(row_a), .out_col(col_a), .out_last(last_a)
  );

  systolic_drain #(.ARRAY_WIDTH(1), .ARRAY_HEIGHT(3), .DATA_WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .c_array_input(c_b),
    .array_reset_n(arn_b), .busy(busy_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_data(data_b), .out_row(row_b), .out_col(col_b), .out_last(last_b)
  );

  beat_t qa[$];
  beat_t qb[$];
  bit    pulse_a, pulse_b, just_rst;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: an accepted start enqueues every element row-major; each handshake pops one.
  task automatic model_step();
    just_rst = reset;
    pulse_a  = 1'b0;
    pulse_b  = 1'b0;
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() == 0) begin
        if (start_a) begin
          for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
              qa.push_back('{c_a[r][c], r, c, (r == 1 && c == 1)});
          pulse_a = 1'b1;
        end
      end else if (ready_a) begin
        void'(qa.pop_front());
      end
      if (qb.size() == 0) begin
        if (start_b) begin
          for (int r = 0; r < 3; r++)
            qb.push_back('{c_b[r][0], r, 0, (r == 2)});
          pulse_b = 1'b1;
        end
      end else if (ready_b) begin
        void'(qb.pop_front());
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] arn_v;
    logic [2:0] arn_w;
    bit         va, vb;
    va = (qa.size() != 0);
    vb = (qb.size() != 0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        arn_v[r*2+c] = arn_a[r][c];
    for (int r = 0; r < 3; r++)
      arn_w[r] = arn_b[r][0];

    check_val("a_valid", 32'(valid_a), 32'(va));
    check_val("a_busy", 32'(busy_a), 32'(va));
    check_val("a_arn", 32'(arn_v), pulse_a ? 32'h0 : 32'hF);
    if (va) begin
      check_val("a_data", 32'(data_a), 32'(qa[0].d));
      check_val("a_row", 32'(row_a), 32'(qa[0].r));
      check_val("a_col", 32'(col_a), 32'(qa[0].c));
      check_val("a_last", 32'(last_a), 32'(qa[0].last));
    end else begin
      check_val("a_idle_last", 32'(last_a), 32'h0);
      check_val("a_idle_row", 32'(row_a), 32'h0);
      check_val("a_idle_col", 32'(col_a), 32'h0);
      if (just_rst) check_val("a_rst_data", 32'(data_a), 32'h0);
    end

    check_val("b_valid", 32'(valid_b), 32'(vb));
    check_val("b_busy", 32'(busy_b), 32'(vb));
    check_val("b_arn", 32'(arn_w), pulse_b ? 32'h0 : 32'h7);
    if (vb) begin
      check_val("b_data", 32'(data_b), 32'(qb[0].d));
      check_val("b_row", 32'(row_b), 32'(qb[0].r));
      check_val("b_col", 32'(col_b), 32'(qb[0].c));
      check_val("b_last", 32'(last_b), 32'(qb[0].last));
    end else begin
      check_val("b_idle_last", 32'(last_b), 32'h0);
      check_val("b_idle_row", 32'(row_b), 32'h0);
      if (just_rst) check_val("b_rst_data", 32'(data_b), 32'h0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic load_a(input logic [15:0] v0, v1, v2, v3);
    c_a[0][0] = v0; c_a[0][1] = v1; c_a[1][0] = v2; c_a[1][1] = v3;
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b0; ready_b = 1'b1;
    load_a(0, 0, 0, 0);
    for (int r = 0; r < 3; r++) c_b[r][0] = '0;
    @(negedge clk);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Basic drain with inputs scrambled right after the capture edge
    load_a(1, 2, 3, 4); start_a = 1'b1;
    tick();
    start_a = 1'b0; load_a(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (5) tick();

    // Backpressure on beat (0,1)
    load_a(1, 2, 3, 4); start_a = 1'b1;
    tick();
    start_a = 1'b0; load_a(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    tick();
    ready_a = 1'b0;
    repeat (3) tick();
    ready_a = 1'b1;
    repeat (4) tick();

    // Start held through a whole drain, including the last-transfer edge
    load_a(16'h11, 16'h22, 16'h33, 16'h44); start_a = 1'b1;
    repeat (10) tick();
    start_a = 1'b0;
    repeat (3) tick();

    // Reset after the second beat, then restart
    load_a(16'hA1, 16'hA2, 16'hA3, 16'hA4); start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    load_a(16'hB1, 16'hB2, 16'hB3, 16'hB4); start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();

    // 3x1 column
    c_b[0][0] = 16'd10; c_b[1][0] = 16'd20; c_b[2][0] = 16'd30; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (4) tick();

    // Randomized traffic on both instances
    repeat (400) begin
      reset   = ($urandom_range(0, 63) == 0);
      start_a = ($urandom_range(0, 3) == 0);
      start_b = ($urandom_range(0, 3) == 0);
      ready_a = ($urandom_range(0, 3) != 0);
      ready_b = ($urandom_range(0, 3) != 0);
      load_a(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      for (int r = 0; r < 3; r++) c_b[r][0] = 16'($urandom);
      tick();
    end
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
